mat_result_writeback: RTL and testbench

//  Downstream stage of the matrix-multiply controller/MAC datapath. Captures each finished MAC

---
 rtl/mat_result_writeback.sv | 141 ++++++++++++++
 tb/tb_mat_result_writeback.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_result_writeback.sv
// Result writeback stage for the matrix-multiply datapath: saturates finished accumulators,
// buffers one result matrix, then streams it out row-major over valid/ready with a last flag.
module mat_result_writeback #(
  parameter int ACC_W     = 19,
  parameter int OUT_W     = 16,
  parameter int N_RESULTS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              capture,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              done_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              full,
  output logic              overflow_err,
  output logic [6:0]        sat_count,
  output logic              job_done
);

  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    COMPLETE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [6:0]       sat_cnt;
  logic             ovf;

  logic [OUT_W-1:0] mem [2**ADDR_W];

  logic             full_w;
  logic             wr_en;
  logic             clamped;
  logic [OUT_W-1:0] sat_val;
  logic [PTR_W-1:0] wr_ptr_post;
  logic             rd_last;
  logic             beat;
  logic [ACC_W-OUT_W:0] acc_hi;

  // In range exactly when every bit from the OUT_W sign position upward agrees.
  always_comb begin
    acc_hi  = acc_in[ACC_W-1:OUT_W-1];
    clamped = !((&acc_hi) || !(|acc_hi));
    sat_val = acc_in[OUT_W-1:0];
    if (clamped) begin
      sat_val = acc_in[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    full_w      = (wr_ptr == PTR_W'(N_RESULTS));
    wr_en       = (state == COLLECT) && capture && !full_w;
    wr_ptr_post = wr_ptr + PTR_W'(wr_en);
    rd_last     = (rd_ptr == wr_ptr - PTR_W'(1));
    beat        = (state == DRAIN) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= sat_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sat_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= COLLECT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sat_cnt <= '0;
            ovf     <= 1'b0;
          end
        end
        COLLECT: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr_post;
            if (clamped && (sat_cnt != '1)) begin
              sat_cnt <= sat_cnt + 7'd1;
            end
          end
          if (capture && full_w) begin
            ovf <= 1'b1;
          end
          // A capture coinciding with done_in is counted before choosing DRAIN vs COMPLETE.
          if (done_in) begin
            state <= (wr_ptr_post != '0) ? DRAIN : COMPLETE;
          end
        end
        DRAIN: begin
          if (beat) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            if (rd_last) begin
              state <= COMPLETE;
            end
          end
        end
        COMPLETE: begin
          if (!start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid    = (state == DRAIN);
    out_data     = out_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;
    out_addr     = out_valid ? rd_ptr[ADDR_W-1:0] : '0;
    out_last     = out_valid && rd_last;
    busy         = (state == COLLECT) || (state == DRAIN);
    full         = full_w;
    overflow_err = ovf;
    sat_count    = sat_cnt;
    job_done     = (state == COMPLETE);
  end

endmodule

// File: tb/tb_mat_result_writeback.sv
// Scoreboard bench for mat_result_writeback: captures push expected beats, the output monitor
// pops and compares them, including stall stability and the last flag.
module tb_mat_result_writeback;

  localparam int ACC_W = 19;
  localparam int OUT_W = 16;
  localparam int NRES  = 64;
  localparam int AW    = 6;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [AW-1:0]    addr;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             capture = 1'b0;
  logic [ACC_W-1:0] acc_in = '0;
  logic             done_in = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_last;
  logic             busy;
  logic             full;
  logic             overflow_err;
  logic [6:0]       sat_count;
  logic             job_done;

  mat_result_writeback #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .N_RESULTS(NRES),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .capture(capture),
    .acc_in(acc_in),
    .done_in(done_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_addr(out_addr),
    .out_last(out_last),
    .busy(busy),
    .full(full),
    .overflow_err(overflow_err),
    .sat_count(sat_count),
    .job_done(job_done)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t sb[$];
  int    exp_n;
  int    exp_sat;
  logic  exp_ovf;
  int    n_xfer;
  int    rdy_pat[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] sat_model(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Output monitor: compares each transfer with the scoreboard and checks stall stability.
  logic             held = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic [AW-1:0]    held_addr;
  logic             held_last;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_data", {16'b0, out_data}, {16'b0, held_data});
        check("stall_addr", {26'b0, out_addr}, {26'b0, held_addr});
        check("stall_last", {31'b0, out_last}, {31'b0, held_last});
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t b;
          b = sb.pop_front();
          check("beat_data", {16'b0, out_data}, {16'b0, b.data});
          check("beat_addr", {26'b0, out_addr}, {26'b0, b.addr});
          check("beat_last", {31'b0, out_last}, {31'b0, (int'(b.addr) == exp_n - 1)});
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_addr = out_addr;
      held_last = out_last;
    end
  end

  task automatic start_job();
    exp_n   = 0;
    exp_sat = 0;
    exp_ovf = 1'b0;
    n_xfer  = 0;
    sb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic cap(input int v, input logic with_done);
    beat_t b;
    capture = 1'b1;
    acc_in  = ACC_W'(v);
    done_in = with_done;
    if (exp_n < NRES) begin
      b.data = sat_model(v);
      b.addr = AW'(exp_n);
      sb.push_back(b);
      if ((v > 32767 || v < -32768) && exp_sat < 127) exp_sat++;
      exp_n++;
    end else begin
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    capture = 1'b0;
    done_in = 1'b0;
  endtask

  task automatic send_done();
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  // Called right after the edge that sampled done_in.
  task automatic drain();
    check("first_valid", {31'b0, out_valid}, {31'b0, (exp_n > 0)});
    for (int c = 0; c < 400 && !job_done; c++) begin
      out_ready = (c < rdy_pat.size()) ? rdy_pat[c][0] : 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("job_done", {31'b0, job_done}, 32'd1);
    check("valid_after_last", {31'b0, out_valid}, 32'd0);
    check("beat_count", n_xfer, exp_n);
    check("sb_empty", sb.size(), 0);
    rdy_pat.delete();
  endtask

  task automatic end_job();
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_complete", {30'b0, job_done, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {16'b0, out_data}, 32'd0);
    check("rst_flags", {28'b0, busy, full, overflow_err, job_done}, 32'd0);
    check("rst_sat", {25'b0, sat_count}, 32'd0);

    // 1: full matrix, free-flowing drain
    start_job();
    for (int i = 0; i < NRES; i++) cap(i, 1'b0);
    check("t1_full", {31'b0, full}, 32'd1);
    send_done();
    drain();
    end_job();

    // 2: saturation both directions
    start_job();
    cap(40000, 1'b0);
    cap(-40000, 1'b0);
    cap(1234, 1'b0);
    check("t2_sat_count", {25'b0, sat_count}, exp_sat);
    send_done();
    drain();
    check("t2_sat_persist", {25'b0, sat_count}, 32'd2);
    end_job();

    // 3: back-pressure pattern
    start_job();
    for (int i = 0; i < 4; i++) cap(-100 * i - 7, 1'b0);
    send_done();
    rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
    drain();
    end_job();

    // 4: overflow past a full buffer
    start_job();
    for (int i = 0; i < NRES + 1; i++) begin
      cap(3 * i - 90, 1'b0);
      if (i == NRES - 2) check("t4_not_full", {31'b0, full}, 32'd0);
      if (i == NRES - 1) begin
        check("t4_full", {31'b0, full}, 32'd1);
        check("t4_no_ovf_yet", {31'b0, overflow_err}, 32'd0);
      end
    end
    check("t4_ovf", {31'b0, overflow_err}, {31'b0, exp_ovf});
    send_done();
    drain();
    end_job();

    // 5: capture coincident with done, then an empty job
    start_job();
    cap(11, 1'b0);
    cap(-22, 1'b0);
    cap(33, 1'b1);
    drain();
    end_job();
    start_job();
    send_done();
    drain();
    end_job();

    // 6: asynchronous reset in the middle of a drain
    start_job();
    for (int i = 0; i < 20; i++) cap(50000 - i, 1'b0);
    send_done();
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("t6_mid_addr", {26'b0, out_addr}, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_data", {16'b0, out_data}, 32'd0);
    check("t6_rst_addr", {26'b0, out_addr}, 32'd0);
    check("t6_rst_flags", {28'b0, busy, full, overflow_err, job_done}, 32'd0);
    check("t6_rst_sat", {25'b0, sat_count}, 32'd0);
    start = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    start_job();
    cap(-70000, 1'b0);
    cap(5, 1'b0);
    check("t6_clean_sat", {25'b0, sat_count}, 32'd1);
    send_done();
    drain();
    end_job();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
